// File: rtl/vecseq_pkg.sv
// Shared opcode and state definitions for the programmable DAC waveform sequencer.
package vecseq_pkg;

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] OP_NOP  = 3'd0;
    localparam logic [OP_W-1:0] OP_HOLD = 3'd1;
    localparam logic [OP_W-1:0] OP_INCR = 3'd2;
    localparam logic [OP_W-1:0] OP_DECR = 3'd3;
    localparam logic [OP_W-1:0] OP_SET  = 3'd4;
    localparam logic [OP_W-1:0] OP_LOOP = 3'd5;
    localparam logic [OP_W-1:0] OP_HALT = 3'd6;

    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } state_e;

    // Opcodes whose duration is set by the parameter and tracked with the rep counter.
    function automatic logic is_multi_cycle(input logic [OP_W-1:0] op);
        return (op == OP_HOLD) || (op == OP_INCR) || (op == OP_DECR);
    endfunction

endpackage

// File: rtl/vecseq_prog_ram.sv
// Program store: synchronous write port, combinational read at the program counter, no reset.
module vecseq_prog_ram
    import vecseq_pkg::*;
#(
    parameter int unsigned PARAM_W = 8,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned AW      = $clog2(DEPTH)
) (
    input  logic               i_clk,
    input  logic               i_we,
    input  logic [AW-1:0]      i_waddr,
    input  logic [OP_W-1:0]    i_wop,
    input  logic [PARAM_W-1:0] i_wparam,
    input  logic [AW-1:0]      i_raddr,
    output logic [OP_W-1:0]    o_rop,
    output logic [PARAM_W-1:0] o_rparam
);

    logic [OP_W+PARAM_W-1:0] r_mem [DEPTH];
    logic [OP_W+PARAM_W-1:0] w_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= {i_wop, i_wparam};
        end
    end

    assign w_rdata  = r_mem[i_raddr];
    assign o_rop    = w_rdata[OP_W+PARAM_W-1:PARAM_W];
    assign o_rparam = w_rdata[PARAM_W-1:0];

endmodule

// File: rtl/vector_seq_gen.sv
// Programmable single-channel DAC waveform sequencer, one instruction step per clock.
// Define VECSEQ_SAT_EN to make INCR/DECR saturate instead of wrapping.
module vector_seq_gen
    import vecseq_pkg::*;
#(
    parameter int unsigned DAC_W   = 8,
    parameter int unsigned PARAM_W = 8,
    parameter int unsigned DEPTH   = 8,
    localparam int unsigned AW     = $clog2(DEPTH)
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic               i_prog_we,
    input  logic [AW-1:0]      i_prog_addr,
    input  logic [OP_W-1:0]    i_prog_op,
    input  logic [PARAM_W-1:0] i_prog_param,
    output logic               o_busy,
    output logic               o_done,
    output logic [DAC_W-1:0]   o_dac_out,
    output logic [AW-1:0]      o_pc_out
);

    state_e             r_state;
    logic               r_busy;
    logic               r_done;
    logic [DAC_W-1:0]   r_dac;
    logic [AW-1:0]      r_pc;
    logic [PARAM_W-1:0] r_rep;

    logic [OP_W-1:0]    w_op;
    logic [PARAM_W-1:0] w_param;
    logic               w_prog_we;
    logic               w_param_zero;
    logic               w_step_done;
    logic [AW-1:0]      w_pc_inc;
    logic [AW-1:0]      w_loop_pc;
    logic [DAC_W-1:0]   w_dac_inc;
    logic [DAC_W-1:0]   w_dac_dec;
    logic [DAC_W-1:0]   w_dac_set;

    // Writes are locked out while a program runs so the executing code cannot change under it.
    assign w_prog_we = i_prog_we && !r_busy;

    vecseq_prog_ram #(
        .PARAM_W (PARAM_W),
        .DEPTH   (DEPTH),
        .AW      (AW)
    ) u_prog_ram (
        .i_clk    (i_clk),
        .i_we     (w_prog_we),
        .i_waddr  (i_prog_addr),
        .i_wop    (i_prog_op),
        .i_wparam (i_prog_param),
        .i_raddr  (r_pc),
        .o_rop    (w_op),
        .o_rparam (w_param)
    );

    assign w_param_zero = (w_param == '0);
    // A zero count behaves as a single step, so it finishes on its first cycle.
    assign w_step_done  = w_param_zero || (r_rep == (w_param - PARAM_W'(1)));
    assign w_pc_inc     = r_pc + AW'(1);
    assign w_loop_pc    = AW'(w_param);
    assign w_dac_set    = DAC_W'(w_param);

`ifdef VECSEQ_SAT_EN
    assign w_dac_inc = (r_dac == {DAC_W{1'b1}}) ? r_dac : r_dac + DAC_W'(1);
    assign w_dac_dec = (r_dac == '0)            ? r_dac : r_dac - DAC_W'(1);
`else
    assign w_dac_inc = r_dac + DAC_W'(1);
    assign w_dac_dec = r_dac - DAC_W'(1);
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dac   <= '0;
            r_pc    <= '0;
            r_rep   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_state <= StRun;
                        r_busy  <= 1'b1;
                        r_pc    <= '0;
                        r_rep   <= '0;
                    end
                end
                StRun: begin
                    if (is_multi_cycle(w_op)) begin
                        if (w_step_done) begin
                            r_pc  <= w_pc_inc;
                            r_rep <= '0;
                        end else begin
                            r_rep <= r_rep + PARAM_W'(1);
                        end
                    end
                    case (w_op)
                        OP_INCR: begin
                            if (!w_param_zero) begin
                                r_dac <= w_dac_inc;
                            end
                        end
                        OP_DECR: begin
                            if (!w_param_zero) begin
                                r_dac <= w_dac_dec;
                            end
                        end
                        OP_HOLD: begin
                        end
                        OP_SET: begin
                            r_dac <= w_dac_set;
                            r_pc  <= w_pc_inc;
                        end
                        OP_LOOP: begin
                            r_pc <= w_loop_pc;
                        end
                        OP_HALT: begin
                            r_state <= StIdle;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                        default: begin
                            // NOP and the reserved opcode
                            r_pc <= w_pc_inc;
                        end
                    endcase
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_dac_out = r_dac;
    assign o_pc_out  = r_pc;

endmodule

// File: tb/tb_vector_seq_gen.sv
// Self-checking bench for vector_seq_gen: expands each program into an expected per-cycle trace.
module tb_vector_seq_gen;
    import vecseq_pkg::*;

    localparam int DAC_W   = 8;
    localparam int PARAM_W = 8;
    localparam int DEPTH   = 8;
    localparam int AW      = 3;
    localparam int DAC_MAX = (1 << DAC_W) - 1;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic               prog_we;
    logic [AW-1:0]      prog_addr;
    logic [2:0]         prog_op;
    logic [PARAM_W-1:0] prog_param;
    logic               busy;
    logic               done;
    logic [DAC_W-1:0]   dac_out;
    logic [AW-1:0]      pc_out;

    always #5 clk = ~clk;

    vector_seq_gen #(
        .DAC_W   (DAC_W),
        .PARAM_W (PARAM_W),
        .DEPTH   (DEPTH)
    ) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_start      (start),
        .i_prog_we    (prog_we),
        .i_prog_addr  (prog_addr),
        .i_prog_op    (prog_op),
        .i_prog_param (prog_param),
        .o_busy       (busy),
        .o_done       (done),
        .o_dac_out    (dac_out),
        .o_pc_out     (pc_out)
    );

    typedef struct {
        int dac;
        int pc;
        bit busy;
        bit done;
    } samp_t;

    samp_t exp_q[$];
    samp_t cmp_e;
    int    n_chk  = 0;
    int    n_pass = 0;

    int m_op [DEPTH];
    int m_par[DEPTH];
    int m_dac;
    int m_pc;
    int obs_dac [256];
    int obs_pc  [256];
    int obs_done[256];

    // One comparison per cycle against the expected trace, away from the active edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            cmp_e = exp_q.pop_front();
            n_chk++;
            if (int'(dac_out) == cmp_e.dac && int'(pc_out) == cmp_e.pc &&
                busy == cmp_e.busy && done == cmp_e.done) begin
                n_pass++;
            end else begin
                $display("FAIL cycle_cmp t=%0t: dac/pc/busy/done got %0d/%0d/%0b/%0b want %0d/%0d/%0b/%0b",
                         $time, dac_out, pc_out, busy, done,
                         cmp_e.dac, cmp_e.pc, cmp_e.busy, cmp_e.done);
            end
        end
    end

    task automatic chk(input string nm, input int act, input int expv);
        n_chk++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d want %0d", nm, act, expv);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int d, input int p, input bit b, input bit dn);
        samp_t s;
        s.dac = d; s.pc = p; s.busy = b; s.done = dn;
        exp_q.push_back(s);
    endtask

    task automatic idle_tick();
        tick();
        push(m_dac, m_pc, 1'b0, 1'b0);
    endtask

    task automatic wr(input int a, input int op, input int par);
        prog_we    = 1'b1;
        prog_addr  = AW'(a);
        prog_op    = 3'(op);
        prog_param = PARAM_W'(par);
        idle_tick();
        prog_we    = 1'b0;
        m_op[a]    = op;
        m_par[a]   = par;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_dac = 0;
        m_pc  = 0;
        push(0, 0, 1'b0, 1'b0);
    endtask

    function automatic int step_dac(input int d, input int delta);
`ifdef VECSEQ_SAT_EN
        if (d + delta > DAC_MAX) return DAC_MAX;
        if (d + delta < 0) return 0;
        return d + delta;
`else
        return (d + delta) & DAC_MAX;
`endif
    endfunction

    // Walk the program instruction by instruction, emitting the outputs seen after each edge.
    task automatic build_trace(input int max_len, output bit halted, output int len);
        int pc, d, c, op, n, nxt;
        halted = 1'b0;
        pc = 0;
        d  = m_dac;
        push(d, 0, 1'b1, 1'b0);
        len = 1;
        while (!halted && len < max_len) begin
            op = m_op[pc];
            n  = m_par[pc];
            if (op == int'(OP_HALT)) begin
                push(d, pc, 1'b0, 1'b1);
                len++;
                halted = 1'b1;
                m_pc = pc;
            end else begin
                c   = ((op == 1 || op == 2 || op == 3) && n > 0) ? n : 1;
                nxt = (op == int'(OP_LOOP)) ? (n % DEPTH) : ((pc + 1) % DEPTH);
                for (int j = 0; j < c && len < max_len; j++) begin
                    if (op == int'(OP_INCR) && n > 0) d = step_dac(d, 1);
                    else if (op == int'(OP_DECR) && n > 0) d = step_dac(d, -1);
                    else if (op == int'(OP_SET)) d = n;
                    push(d, (j == c - 1) ? nxt : pc, 1'b1, 1'b0);
                    len++;
                end
                pc = nxt;
            end
        end
        m_dac = d;
    endtask

    task automatic record(input int i);
        obs_dac[i]  = int'(dac_out);
        obs_pc[i]   = int'(pc_out);
        obs_done[i] = int'(done);
    endtask

    // inj pulses a write to slot 2 and a start while the program is running.
    task automatic run_prog(input int max_len, input bit inj, output bit halted, output int len);
        start = 1'b1;
        tick();
        start   = 1'b0;
        prog_we = 1'b0;
        build_trace(max_len, halted, len);
        record(0);
        for (int i = 1; i < len; i++) begin
            if (inj && i == 2) begin
                prog_we    = 1'b1;
                prog_addr  = AW'(2);
                prog_op    = OP_SET;
                prog_param = PARAM_W'(99);
                start      = 1'b1;
            end
            tick();
            prog_we = 1'b0;
            start   = 1'b0;
            record(i);
        end
    endtask

    initial begin
        bit h;
        int len;
        int dsum;
        int op, par;

        reset = 1'b1; start = 1'b0; prog_we = 1'b0;
        prog_addr = '0; prog_op = '0; prog_param = '0;
        repeat (3) tick();
        reset = 1'b0;
        m_dac = 0; m_pc = 0;
        chk("rst_dac", int'(dac_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_pc", int'(pc_out), 0);
        push(0, 0, 1'b0, 1'b0);

        // SET 10, INCR 5, HALT; slot 0 written in the start cycle
        wr(1, OP_INCR, 5);
        wr(2, OP_HALT, 0);
        m_op[0] = OP_SET; m_par[0] = 10;
        prog_we = 1'b1; prog_addr = '0; prog_op = OP_SET; prog_param = 8'd10;
        run_prog(50, 1'b0, h, len);
        chk("t1_len", len, 8);
        chk("t1_first", obs_dac[1], 10);
        chk("t1_mid", obs_dac[5], 14);
        chk("t1_end_dac", obs_dac[7], 15);
        chk("t1_done", obs_done[7], 1);
        idle_tick();
        idle_tick();
        chk("t1_hold_dac", int'(dac_out), 15);
        chk("t1_idle_busy", int'(busy), 0);

        // SET 250, INCR 10, HALT
        wr(0, OP_SET, 250);
        wr(1, OP_INCR, 10);
        run_prog(50, 1'b0, h, len);
`ifdef VECSEQ_SAT_EN
        chk("t2_end_dac", obs_dac[len-1], 255);
`else
        chk("t2_end_dac", obs_dac[len-1], 4);
`endif
        idle_tick();

        // triangle 0..3..0 with period 7, never halts
        wr(0, OP_SET, 0);
        wr(1, OP_INCR, 3);
        wr(2, OP_DECR, 3);
        wr(3, OP_LOOP, 1);
        run_prog(30, 1'b0, h, len);
        chk("t3_peak_a", obs_dac[4], 3);
        chk("t3_low_a", obs_dac[7], 0);
        chk("t3_peak_b", obs_dac[11], 3);
        chk("t3_low_b", obs_dac[14], 0);
        dsum = 0;
        for (int i = 0; i < len; i++) dsum += obs_done[i];
        chk("t3_no_done", dsum, 0);
        do_reset();

        // HOLD 0 and INCR 0 are single-cycle
        wr(0, OP_SET, 7);
        wr(1, OP_HOLD, 0);
        wr(2, OP_INCR, 0);
        wr(3, OP_HALT, 0);
        run_prog(50, 1'b0, h, len);
        chk("t4_pc_hold", obs_pc[2], 2);
        chk("t4_pc_incr", obs_pc[3], 3);
        chk("t4_done", obs_done[4], 1);
        chk("t4_dac", obs_dac[4], 7);

        // reset mid INCR 100, then restart the preserved program
        do_reset();
        wr(0, OP_INCR, 100);
        wr(1, OP_HALT, 0);
        run_prog(41, 1'b0, h, len);
        chk("t5_step40", obs_dac[40], 40);
        do_reset();
        chk("t5_rst_dac", int'(dac_out), 0);
        chk("t5_rst_busy", int'(busy), 0);
        start = 1'b1;
        do_reset();
        start = 1'b0;
        idle_tick();
        chk("t5_rst_wins", int'(busy), 0);
        run_prog(200, 1'b0, h, len);
        chk("t5_len", len, 102);
        chk("t5_end_dac", obs_dac[len-1], 100);
        idle_tick();

        // writes and start while busy are ignored; opcode 7 acts as NOP
        wr(0, OP_SET, 5);
        wr(1, OP_HOLD, 4);
        wr(2, OP_INCR, 2);
        wr(3, 7, 9);
        wr(4, OP_HALT, 0);
        run_prog(50, 1'b1, h, len);
        chk("t6_len", len, 10);
        chk("t6_end_dac", obs_dac[9], 7);
        chk("t6_halt_pc", obs_pc[9], 4);
        idle_tick();
        run_prog(50, 1'b0, h, len);
        chk("t6_rerun_dac", obs_dac[len-1], 7);
        idle_tick();

        // random programs
        for (int r = 0; r < 12; r++) begin
            for (int a = 0; a < DEPTH; a++) begin
                op  = int'($urandom_range(0, 7));
                par = (op >= 1 && op <= 3) ? int'($urandom_range(0, 5)) : int'($urandom_range(0, 255));
                wr(a, op, par);
            end
            run_prog(40, 1'b0, h, len);
            if (!h) do_reset();
            else idle_tick();
            idle_tick();
        end

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) tick();
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
